uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NREQ byte requesters
// Optional burst-hold of the current owner is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
   parameter int NREQ = 4,
   parameter int DBIT = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DBIT-1:0] din,
   input  logic [NREQ-1:0]      lock,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      done,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic                 tx_start,
   output logic [DBIT-1:0]      tx_dout,
   input  logic                 tx_done_tick
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   last_owner, last_owner_nx;
   logic [IW-1:0]   owner, owner_nx;
   logic [IW-1:0]   win;
   logic            found;
   logic            burst;
   logic [NREQ-1:0] ack_nx, done_nx, gnt_nx;
   logic            tx_start_nx;
   logic [DBIT-1:0] tx_dout_nx;
   int              idx;

`ifdef UART_ARB_LOCK_EN
   assign burst = req[owner] & lock[owner];
`else
   // lock is ignored in this build; every byte is arbitrated
   assign burst = 1'b0 & (^lock);
`endif

   // Round-robin search starting just after the previous owner
   always_comb begin
      found = 1'b0;
      win   = last_owner;
      idx   = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_owner) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx[IW-1:0];
         end
      end
   end

   always_comb begin
      state_nx      = state;
      last_owner_nx = last_owner;
      owner_nx      = owner;
      ack_nx        = '0;
      done_nx       = '0;
      gnt_nx        = gnt;
      tx_start_nx   = 1'b0;
      tx_dout_nx    = tx_dout;
      case (state)
         IDLE: begin
            if (found) begin
               owner_nx   = win;
               gnt_nx     = NREQ'(1) << win;
               ack_nx     = NREQ'(1) << win;
               tx_dout_nx = din[win*DBIT +: DBIT];
               state_nx   = START;
            end
         end
         START: begin
            tx_start_nx = 1'b1;
            state_nx    = WAIT;
         end
         WAIT: begin
            if (tx_done_tick) begin
               done_nx = NREQ'(1) << owner;
               if (burst) begin
                  ack_nx     = NREQ'(1) << owner;
                  tx_dout_nx = din[owner*DBIT +: DBIT];
                  state_nx   = START;
               end else begin
                  last_owner_nx = owner;
                  gnt_nx        = '0;
                  state_nx      = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_owner <= IW'(NREQ - 1);
         owner      <= '0;
         ack        <= '0;
         done       <= '0;
         gnt        <= '0;
         busy       <= 1'b0;
         tx_start   <= 1'b0;
         tx_dout    <= '0;
      end else begin
         state      <= state_nx;
         last_owner <= last_owner_nx;
         owner      <= owner_nx;
         ack        <= ack_nx;
         done       <= done_nx;
         gnt        <= gnt_nx;
         busy       <= (state_nx != IDLE);
         tx_start   <= tx_start_nx;
         tx_dout    <= tx_dout_nx;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int DBIT = 8;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic [NREQ-1:0]      req = '0;
   logic [NREQ*DBIT-1:0] din = '0;
   logic [NREQ-1:0]      lock = '0;
   logic [NREQ-1:0]      ack, done, gnt;
   logic                 busy, tx_start;
   logic [DBIT-1:0]      tx_dout;
   logic                 tx_done_tick = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .din(din), .lock(lock),
      .ack(ack), .done(done), .gnt(gnt), .busy(busy), .tx_start(tx_start),
      .tx_dout(tx_dout), .tx_done_tick(tx_done_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      req = '0;
      lock = '0;
      tx_done_tick = 1'b0;
      @(negedge clk);
      check("rst_ack", 32'(ack), 0);
      check("rst_done", 32'(done), 0);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_tx_dout", 32'(tx_dout), 0);
      reset_n = 1'b1;
   endtask

   // One complete byte: ack/gnt, tx_start with the byte, then done one cycle after tx_done_tick
   task automatic do_byte(input int o, input logic [7:0] b, input bit drop_lock, input bit hold);
      int n;
      n = 0;
      while (ack == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("ack_seen", 32'(|ack), 1);
      check("ack", 32'(ack), 32'(1) << o);
      check("gnt", 32'(gnt), 32'(1) << o);
      check("busy", 32'(busy), 1);
      if (drop_lock) lock = '0;
      @(negedge clk);
      check("tx_start", 32'(tx_start), 1);
      check("tx_dout", 32'(tx_dout), 32'(b));
      check("ack_one_cycle", 32'(ack), 0);
      @(negedge clk);
      check("tx_start_one_cycle", 32'(tx_start), 0);
      check("no_early_done", 32'(done), 0);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      check("done", 32'(done), 32'(1) << o);
      check("gnt_after_done", 32'(gnt), hold ? (32'(1) << o) : 0);
      check("ack_with_done", 32'(ack), hold ? (32'(1) << o) : 0);
   endtask

   initial begin
      // single request, byte A5
      do_reset();
      din[7:0] = 8'hA5;
      req = 4'b0001;
      do_byte(0, 8'hA5, 0, 0);
      req = '0;
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_gnt", 32'(gnt), 0);
      check("idle_tx_dout_held", 32'(tx_dout), 32'h A5);

      // all requesting: strict rotation from requester 0
      do_reset();
      din = {8'h33, 8'h22, 8'h11, 8'h00};
      req = 4'b1111;
      for (int i = 0; i < 8; i++) do_byte(i % 4, 8'(8'h11 * (i % 4)), 0, 0);
      req = '0;

      // reset in WAIT with requester 2 owning: nothing completes, then normal grant
      do_reset();
      din = {8'h00, 8'h5C, 8'h00, 8'h00};
      req = 4'b0100;
      @(negedge clk);
      check("r2_ack", 32'(ack), 32'h4);
      @(negedge clk);
      check("r2_tx_start", 32'(tx_start), 1);
      @(negedge clk);
      reset_n = 1'b0;
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      check("mid_rst_outs", 32'({ack, done, gnt, busy, tx_start}), 0);
      check("mid_rst_tx_dout", 32'(tx_dout), 0);
      reset_n = 1'b1;
      do_byte(2, 8'h5C, 0, 0);
      req = '0;

      // tx_done_tick in IDLE and in START is ignored
      do_reset();
      din[7:0] = 8'h3C;
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      check("idle_tick_done", 32'(done), 0);
      check("idle_tick_busy", 32'(busy), 0);
      req = 4'b0001;
      @(negedge clk);
      check("start_ack", 32'(ack), 1);
      req = '0;
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      check("start_tick_tx_start", 32'(tx_start), 1);
      check("start_tick_done", 32'(done), 0);
      check("start_tick_busy", 32'(busy), 1);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      check("late_done", 32'(done), 1);

      // burst hold request from requester 0
      do_reset();
      din = {8'h00, 8'h00, 8'hB1, 8'hB0};
      req = 4'b0011;
      lock = 4'b0001;
`ifdef UART_ARB_LOCK_EN
      do_byte(0, 8'hB0, 0, 1);
      do_byte(0, 8'hB0, 0, 1);
      do_byte(0, 8'hB0, 1, 0);
      do_byte(1, 8'hB1, 0, 0);
`else
      do_byte(0, 8'hB0, 0, 0);
      do_byte(1, 8'hB1, 0, 0);
      do_byte(0, 8'hB0, 0, 0);
`endif
      req = '0;
      lock = '0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
